// File: rtl/instr_load_pkg.sv
// Shared types and helpers for the instruction-memory reload sequencer.
package instr_load_pkg;

  localparam int unsigned DEPTH_DEFAULT = 32;
  localparam int unsigned WORD_BYTES    = 4;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    LOAD,
    FLUSH,
    RESTART
  } state_e;

  // Requested word count limited to the memory depth.
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/load_word_counter.sv
// Word index for the load stream, with a last-beat compare against the latched length.
module load_word_counter #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned LEN_W = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr,
  input  logic                     inc,
  input  logic [LEN_W-1:0]         len,
  output logic [$clog2(DEPTH):0]   idx,
  output logic                     last_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH) + 1;
  localparam int unsigned CMP_W = (IDX_W > LEN_W) ? IDX_W : LEN_W;

  always_ff @(posedge clk_i) begin
    if (rst_i)    idx <= '0;
    else if (clr) idx <= '0;
    else if (inc) idx <= idx + IDX_W'(1);
  end

  // Compared as idx+1 == len so a zero length never matches.
  assign last_c = (CMP_W'(idx) + CMP_W'(1)) == CMP_W'(len);

endmodule

// File: rtl/instr_load_ctrl.sv
// Holds the CPU, streams instruction words into memory from address 0, then restarts the CPU.
module instr_load_ctrl
  import instr_load_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned LEN_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_req_i,
  input  logic [LEN_W-1:0] load_len_i,
  input  logic             wvalid_i,
  input  logic [31:0]      wdata_i,
  output logic             wready_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_waddr_o,
  output logic [31:0]      mem_wdata_o,
  output logic             cpu_hold_o,
  output logic             cpu_rst_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH) + 1;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [IDX_W-1:0]   idx;
  logic               last_c;
  logic               accept_c;
  logic               clr_c;

  assign accept_c = wvalid_i & wready_o;

  load_word_counter #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (clr_c),
    .inc    (accept_c),
    .len    (len_q),
    .idx    (idx),
    .last_c (last_c)
  );

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    clr_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req_i) begin
          clr_c   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD:    state_d = (len_q == '0) ? RESTART : LOAD;
      LOAD:    if (accept_c && last_c) state_d = FLUSH;
      FLUSH:   state_d = RESTART;
      RESTART: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched length and outputs registered from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      wready_o    <= 1'b0;
      cpu_hold_o  <= 1'b0;
      busy_o      <= 1'b0;
      cpu_rst_o   <= 1'b0;
      done_o      <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_waddr_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      state_q    <= state_d;
      if (state_q == IDLE && load_req_i)
        len_q <= LEN_W'(clamp_len(32'(load_len_i), 32'(DEPTH)));
      wready_o   <= (state_d == LOAD);
      cpu_hold_o <= (state_d != IDLE);
      busy_o     <= (state_d != IDLE);
      cpu_rst_o  <= (state_d == RESTART);
      done_o     <= (state_d == RESTART);
      mem_we_o   <= accept_c;
      if (accept_c) begin
        mem_waddr_o <= 32'(idx) * 32'(WORD_BYTES);
        mem_wdata_o <= wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Scenario bench for instr_load_ctrl with a write scoreboard and a per-cycle output model.
module tb_instr_load_ctrl;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned LEN_W = 6;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             load_req_i = 1'b0;
  logic [LEN_W-1:0] load_len_i = '0;
  logic             wvalid_i = 1'b0;
  logic [31:0]      wdata_i = '0;
  logic             wready_o, mem_we_o, cpu_hold_o, cpu_rst_o, busy_o, done_o;
  logic [31:0]      mem_waddr_o, mem_wdata_o;

  always #5 clk = ~clk;

  instr_load_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .load_req_i  (load_req_i),
    .load_len_i  (load_len_i),
    .wvalid_i    (wvalid_i),
    .wdata_i     (wdata_i),
    .wready_o    (wready_o),
    .mem_we_o    (mem_we_o),
    .mem_waddr_o (mem_waddr_o),
    .mem_wdata_o (mem_wdata_o),
    .cpu_hold_o  (cpu_hold_o),
    .cpu_rst_o   (cpu_rst_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          n_wr = 0, n_done = 0, n_rst = 0;
  logic [31:0] wbuf [0:63];

  // {wready, hold, rst, busy, done, we}
  function automatic logic [5:0] outs();
    return {wready_o, cpu_hold_o, cpu_rst_o, busy_o, done_o, mem_we_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every memory write must match the next expected write.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (mem_we_o) begin
      n_wr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", mem_waddr_o, mem_wdata_o);
      end else begin
        e = exp_q.pop_front();
        if ({mem_waddr_o, mem_wdata_o} !== e) begin
          errors++;
          $display("FAIL write addr=%h data=%h expected addr=%h data=%h",
                   mem_waddr_o, mem_wdata_o, e.addr, e.data);
        end
      end
    end
    if (done_o)    n_done++;
    if (cpu_rst_o) n_rst++;
  end

  // Drives one load and checks outputs every cycle against the expected sequence.
  task automatic run_load(input int len, input logic [7:0] vmask, input int vlen,
                          input int rst_at, input int req_at, input bit req_restart);
    int         eff, beats, p, cyc;
    logic       v, acc_prev;
    logic [5:0] exp;
    eff = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    load_req_i = 1'b1;
    load_len_i = LEN_W'(len);
    tick();
    load_req_i = 1'b0;
    exp = 6'b010100;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL hold_state got=%b exp=%b", outs(), exp);
    end
    tick();
    beats = 0; p = 0; cyc = 0; acc_prev = 1'b0;
    while (beats < eff && cyc < 200) begin
      exp = {5'b11010, acc_prev};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL load_state beat=%0d got=%b exp=%b", beats, outs(), exp);
      end
      if (rst_at >= 0 && beats == rst_at) begin
        wvalid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if ({outs(), mem_waddr_o, mem_wdata_o} !== 70'd0) begin
          errors++;
          $display("FAIL reset_mid got=%b addr=%h data=%h exp all zero",
                   outs(), mem_waddr_o, mem_wdata_o);
        end
        return;
      end
      v = (p < vlen) ? vmask[p] : 1'b1;
      p++;
      load_req_i = (req_at >= 0 && beats == req_at);
      wvalid_i   = v;
      wdata_i    = wbuf[beats];
      if (v) begin
        exp_q.push_back('{addr: 32'(beats * 4), data: wbuf[beats]});
        beats++;
      end
      acc_prev = v;
      tick();
      cyc++;
    end
    load_req_i = 1'b0;
    wvalid_i   = 1'b0;
    exp = 6'b010101;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL flush_state got=%b exp=%b", outs(), exp);
    end
    tick();
    exp = 6'b011110;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL restart_state got=%b exp=%b", outs(), exp);
    end
    if (eff == 0) begin
      // len 0 arrives here directly from HOLD; no FLUSH expected
    end
    load_req_i = req_restart;
    tick();
    load_req_i = 1'b0;
    checks++;
    if (outs() !== 6'b000000) begin
      errors++;
      $display("FAIL idle_after got=%b exp=%b", outs(), 6'b000000);
    end
    tick();
    checks++;
    if (outs() !== 6'b000000) begin
      errors++;
      $display("FAIL idle_stays got=%b exp=%b", outs(), 6'b000000);
    end
  endtask

  task automatic run_zero();
    load_req_i = 1'b1;
    load_len_i = '0;
    tick();
    load_req_i = 1'b0;
    checks++;
    if (outs() !== 6'b010100) begin
      errors++;
      $display("FAIL zero_hold got=%b exp=%b", outs(), 6'b010100);
    end
    tick();
    checks++;
    if (outs() !== 6'b011110) begin
      errors++;
      $display("FAIL zero_restart got=%b exp=%b", outs(), 6'b011110);
    end
    tick();
    checks++;
    if (outs() !== 6'b000000) begin
      errors++;
      $display("FAIL zero_idle got=%b exp=%b", outs(), 6'b000000);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    checks++;
    if ({outs(), mem_waddr_o, mem_wdata_o} !== 70'd0) begin
      errors++;
      $display("FAIL reset got=%b addr=%h data=%h exp all zero", outs(), mem_waddr_o, mem_wdata_o);
    end
  endtask

  task automatic check_counts(input string name, input int wr0, input int dn0, input int rs0,
                              input int ewr, input int edn);
    tick();
    checks++;
    if (n_wr - wr0 != ewr || n_done - dn0 != edn || n_rst - rs0 != edn || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s writes=%0d done=%0d rst=%0d pending=%0d exp writes=%0d done=%0d",
               name, n_wr - wr0, n_done - dn0, n_rst - rs0, exp_q.size(), ewr, edn);
    end
  endtask

  task automatic test_basic();
    int wr0 = n_wr, dn0 = n_done, rs0 = n_rst;
    wbuf[0] = 32'h20010005; wbuf[1] = 32'h20020007; wbuf[2] = 32'h00221820;
    run_load(3, 8'h00, 0, -1, -1, 1'b0);
    check_counts("basic_counts", wr0, dn0, rs0, 3, 1);
  endtask

  task automatic test_gaps();
    int wr0 = n_wr, dn0 = n_done, rs0 = n_rst;
    for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
    run_load(2, 8'b0000_1001, 4, -1, -1, 1'b0);
    check_counts("gap_counts", wr0, dn0, rs0, 2, 1);
  endtask

  task automatic test_zero_len();
    int wr0 = n_wr, dn0 = n_done, rs0 = n_rst;
    run_zero();
    check_counts("zero_counts", wr0, dn0, rs0, 0, 1);
  endtask

  task automatic test_clamp();
    int wr0 = n_wr, dn0 = n_done, rs0 = n_rst;
    for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
    run_load(40, 8'h00, 0, -1, -1, 1'b0);
    check_counts("clamp_counts", wr0, dn0, rs0, 32, 1);
  endtask

  task automatic test_reset_mid();
    int wr0 = n_wr, dn0 = n_done, rs0 = n_rst;
    for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
    run_load(5, 8'h00, 0, 2, -1, 1'b0);
    check_counts("reset_mid_counts", wr0, dn0, rs0, 2, 0);
  endtask

  task automatic test_req_mid();
    int wr0 = n_wr, dn0 = n_done, rs0 = n_rst;
    for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
    run_load(4, 8'h00, 0, -1, 1, 1'b0);
    check_counts("req_mid_counts", wr0, dn0, rs0, 4, 1);
  endtask

  task automatic test_back_to_back();
    int wr0 = n_wr, dn0 = n_done, rs0 = n_rst;
    for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
    run_load(1, 8'h00, 0, -1, -1, 1'b1);
    run_load(6, 8'b0010_0110, 6, -1, -1, 1'b0);
    check_counts("b2b_counts", wr0, dn0, rs0, 7, 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_clamp();
    test_reset_mid();
    test_req_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
